game_timer_bcd: RTL and testbench
=================================

// Module: game_timer_bcd
// PURPOSE
//  Parametrised mm:ss game clock in BCD for the fusball match screen.
//  Counts down from a preset or up to a limit, advancing once per one-second tick strobe.
//  Supports start/pause/resume/reload, a low-time warning flag and a one-cycle expiry pulse.
//  Sits between the 1 Hz tick generator and the score/time seven-segment and HUD drawers.
// PARAMETERS
//  START_MM   2    preset minutes, 0..99 (down: start value; up: limit minutes)
//  START_SS   0    preset seconds, 0..59 (down: start value; up: limit seconds)
//  WARN_SEC   10   warning threshold, in remaining seconds, 0..5999
// PORTS
//  clk           in   1  system clock
//  resetN        in   1  asynchronous reset, active-low
//  tick          in   1  one-clock strobe, once per second
//  start         in   1  level/pulse: IDLE->RUN, PAUSED->RUN
//  pause         in   1  pulse: RUN->PAUSED
//  load          in   1  pulse: reload preset, go IDLE (highest priority)
//  mode_up       in   1  0=count down from preset, 1=count up 00:00->preset; sampled on load/reset only
//  sec_ones      out  4  BCD seconds units 0..9
//  sec_tens      out  4  BCD seconds tens 0..5
//  min_ones      out  4  BCD minutes units 0..9
//  min_tens      out  4  BCD minutes tens 0..9
//  running       out  1  high in RUN
//  warning       out  1  remaining seconds <= WARN_SEC and > 0, state RUN or PAUSED
//  time_up       out  1  level, high in DONE
//  time_up_pulse out  1  one-cycle strobe on entry to DONE
// BEHAVIOUR
//  Reset: state IDLE, mode latched from mode_up=0 (down); digits = preset (START_MM:START_SS);
//   running=0, warning=0, time_up=0, time_up_pulse=0.
//  States: IDLE, RUN, PAUSED, DONE. All outputs registered; no combinational input->output paths.
//  Priority per cycle: load > pause > start > tick.
//  load: digits = preset (down) or 00:00 (up); mode latched from mode_up; state IDLE; pulse 0. Valid in any state.
//  IDLE: start -> RUN next cycle. Ticks ignored.
//  RUN: pause -> PAUSED. A tick in the same cycle as pause is dropped.
//   A tick with no pause applies one step on that edge.
//  PAUSED: start -> RUN. Ticks ignored. Digits held.
//  DONE: start, pause and tick ignored. Only load or reset leaves DONE.
//  Down step: decrement BCD with borrow: ss 00 -> 59 with minute-1. Units 0 -> 9 with tens-1.
//   Step that reaches 00:00 -> DONE on the same edge; time_up_pulse high for the following cycle only.
//  Up step: increment BCD with carry: units 9 -> 0, sec tens 5 -> 0 with minute+1.
//   Step that makes digits equal preset -> DONE, with the same pulse rule.
//  Preset 00:00 with start: IDLE -> RUN, then DONE on the first tick (no step).
//  Digits never leave legal BCD range; minutes do not wrap past 99 or below 00.
//  warning: remaining = preset-elapsed (up) or current value (down), in seconds, from registered digits.
//   Updates one cycle after the digits change. Forced 0 in IDLE and DONE.
//  Reset mid-run: immediate asynchronous return to the reset values; no pulse emitted.
// TESTING
//  1) Reset, start, 120 ticks (down, 02:00) -> 01:59 after tick 1; 01:00 after tick 60;
//     00:00 and DONE after tick 120; time_up_pulse exactly 1 cycle; time_up stays 1.
//  2) RUN at 00:11, WARN_SEC=10 -> warning 0; next tick 00:10 -> warning 1; stays 1 until 00:00, then 0.
//  3) RUN at 01:30, pause together with tick -> digits stay 01:30, running 0;
//     5 ticks then start -> 01:30 held; next tick -> 01:29.
//  4) mode_up=1 then load, start, preset 00:05 -> 00:01..00:04, DONE at 00:05; further ticks ignored.
//  5) DONE, then load+start same cycle -> digits 02:00, IDLE; start next cycle -> RUN; no spurious pulse.
//  6) resetN low at 00:37 mid-run -> immediate 02:00, IDLE, all flags 0; ticks after release ignored until start.

Source files
------------

// File: rtl/game_timer_bcd.sv
// mm:ss BCD match clock: counts down from a preset or up to it, one step per tick strobe.
// Exposes run/warning/expiry status to the seven-segment and HUD drawers.
module game_timer_bcd #(
    parameter int START_MM = 2,
    parameter int START_SS = 0,
    parameter int WARN_SEC = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic       mode_up,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       warning,
    output logic       time_up,
    output logic       time_up_pulse
);

    localparam logic [15:0] PRESET_BCD = {4'(START_MM / 10), 4'(START_MM % 10),
                                          4'(START_SS / 10), 4'(START_SS % 10)};
    localparam logic [12:0] PRESET_SEC = 13'(START_MM * 60 + START_SS);
    localparam logic [12:0] WARN_LIM   = 13'(WARN_SEC);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t      state;
    logic        mode;
    logic [15:0] cur, dn, up, nxt, term;
    logic [12:0] cur_sec, rem;
    logic        warn_hit;

    assign cur = {min_tens, min_ones, sec_tens, sec_ones};

    // BCD decrement with borrow; never reached from 00:00 because that is terminal
    always_comb begin
        dn = cur;
        if (sec_ones != 4'd0) dn[3:0] = sec_ones - 4'd1;
        else begin
            dn[3:0] = 4'd9;
            if (sec_tens != 4'd0) dn[7:4] = sec_tens - 4'd1;
            else begin
                dn[7:4] = 4'd5;
                if (min_ones != 4'd0) dn[11:8] = min_ones - 4'd1;
                else begin
                    dn[11:8] = 4'd9;
                    if (min_tens != 4'd0) dn[15:12] = min_tens - 4'd1;
                end
            end
        end
    end

    always_comb begin
        up = cur;
        if (sec_ones != 4'd9) up[3:0] = sec_ones + 4'd1;
        else begin
            up[3:0] = 4'd0;
            if (sec_tens != 4'd5) up[7:4] = sec_tens + 4'd1;
            else begin
                up[7:4] = 4'd0;
                if (min_ones != 4'd9) up[11:8] = min_ones + 4'd1;
                else begin
                    up[11:8] = 4'd0;
                    if (min_tens != 4'd9) up[15:12] = min_tens + 4'd1;
                end
            end
        end
    end

    assign nxt  = mode ? up : dn;
    assign term = mode ? PRESET_BCD : 16'h0000;

    assign cur_sec = 13'(min_tens) * 13'd600 + 13'(min_ones) * 13'd60
                   + 13'(sec_tens) * 13'd10 + 13'(sec_ones);
    assign rem = !mode ? cur_sec :
                 (cur_sec <= PRESET_SEC) ? PRESET_SEC - cur_sec : 13'd0;
    assign warn_hit = (rem != 13'd0) && (rem <= WARN_LIM);

    assign running = (state == RUN);
    assign time_up = (state == DONE);

    // warning tracks the state being entered so it is already low in IDLE and DONE
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            mode          <= 1'b0;
            {min_tens, min_ones, sec_tens, sec_ones} <= PRESET_BCD;
            warning       <= 1'b0;
            time_up_pulse <= 1'b0;
        end else begin
            time_up_pulse <= 1'b0;
            warning       <= warn_hit && (state == RUN || state == PAUSED);
            if (load) begin
                mode    <= mode_up;
                {min_tens, min_ones, sec_tens, sec_ones} <= mode_up ? 16'h0000 : PRESET_BCD;
                state   <= IDLE;
                warning <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state   <= RUN;
                        warning <= warn_hit;
                    end
                    RUN: begin
                        if (pause) state <= PAUSED;
                        else if (tick) begin
                            if (cur == term || nxt == term) begin
                                state         <= DONE;
                                time_up_pulse <= 1'b1;
                                warning       <= 1'b0;
                            end
                            if (cur != term) {min_tens, min_ones, sec_tens, sec_ones} <= nxt;
                        end
                    end
                    PAUSED: if (start) state <= RUN;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd: two instances (02:00/warn 10 and 00:05/warn 3) sharing stimulus,
// directed scenario tasks plus a random phase against a seconds-based model.
module tb_game_timer_bcd;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic tick = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0, mode_up = 1'b0;
    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic run0, warn0, tu0, tup0, run1, warn1, tu1, tup1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_timer_bcd #(.START_MM(2), .START_SS(0), .WARN_SEC(10)) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause),
        .load(load), .mode_up(mode_up),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .warning(warn0), .time_up(tu0), .time_up_pulse(tup0));

    game_timer_bcd #(.START_MM(0), .START_SS(5), .WARN_SEC(3)) dut5 (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause),
        .load(load), .mode_up(mode_up),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .warning(warn1), .time_up(tu1), .time_up_pulse(tup1));

    logic [15:0] dig0, dig1;
    logic [3:0]  flg0, flg1;
    assign dig0 = {mt0, mo0, st0, so0};
    assign dig1 = {mt1, mo1, st1, so1};
    assign flg0 = {run0, warn0, tu0, tup0};
    assign flg1 = {run1, warn1, tu1, tup1};

    // Reference model: time kept as plain seconds, state as a small code
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DONE = 2'd3;
    typedef struct packed {
        logic [1:0] st;
        logic       mode;
        int         cur;
        logic       pulse;
        logic       warn;
    } mdl_t;

    mdl_t mdl [2];
    int   pre [2] = '{120, 5};
    int   wrn [2] = '{10, 3};

    function automatic mdl_t model_next(mdl_t m, int p, int w, logic t, logic s,
                                        logic pz, logic l, logic mu);
        mdl_t n;
        int   left, goal;
        n       = m;
        n.pulse = 1'b0;
        left    = m.mode ? p - m.cur : m.cur;
        goal    = m.mode ? p : 0;
        if (l) begin
            n.st   = S_IDLE;
            n.mode = mu;
            n.cur  = mu ? 0 : p;
        end else if (m.st == S_RUN) begin
            if (pz) n.st = S_PAUSED;
            else if (t) begin
                if (m.cur != goal) n.cur = m.mode ? m.cur + 1 : m.cur - 1;
                if (n.cur == goal) begin
                    n.st    = S_DONE;
                    n.pulse = 1'b1;
                end
            end
        end else if ((m.st == S_IDLE || m.st == S_PAUSED) && s) n.st = S_RUN;
        n.warn = (n.st == S_RUN || n.st == S_PAUSED) && left > 0 && left <= w;
        return n;
    endfunction

    always @(posedge clk or negedge resetN) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetN) mdl[k] <= '{st: S_IDLE, mode: 1'b0, cur: pre[k], pulse: 1'b0, warn: 1'b0};
            else mdl[k] <= model_next(mdl[k], pre[k], wrn[k], tick, start, pause, load, mode_up);
        end
    end

    function automatic logic [19:0] exp_vec(mdl_t m);
        int mm, ss;
        mm = m.cur / 60;
        ss = m.cur % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                m.st == S_RUN, m.warn, m.st == S_DONE, m.pulse};
    endfunction

    // Called at a falling edge; holds the inputs across one rising edge
    task automatic step(input logic t, input logic s, input logic pz, input logic l, input logic mu);
        tick = t; start = s; pause = pz; load = l; mode_up = mu;
        @(negedge clk);
        tick = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dig0 !== 16'h0200 || flg0 !== 4'b0000) begin
            failures++; $display("FAIL reset_a got=%h/%b want=0200/0000", dig0, flg0);
        end
        checks++;
        if (dig1 !== 16'h0005 || flg1 !== 4'b0000) begin
            failures++; $display("FAIL reset_b got=%h/%b want=0005/0000", dig1, flg1);
        end
        resetN = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dig0 !== 16'h0200 || run0 !== 1'b0) begin
            failures++; $display("FAIL idle_tick got=%h run=%b want=0200 run=0", dig0, run0);
        end
    endtask

    task automatic test_countdown;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 120; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 1 || i == 60) begin
                checks++;
                if (dig0 !== (i == 1 ? 16'h0159 : 16'h0100) || run0 !== 1'b1) begin
                    failures++; $display("FAIL countdown_t%0d got=%h run=%b", i, dig0, run0);
                end
            end
        end
        checks++;
        if (dig0 !== 16'h0000 || tu0 !== 1'b1 || tup0 !== 1'b1 || run0 !== 1'b0) begin
            failures++; $display("FAIL countdown_end got=%h/%b want=0000/0011", dig0, flg0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tup0 !== 1'b0 || tu0 !== 1'b1 || dig0 !== 16'h0000) begin
            failures++; $display("FAIL countdown_pulse got=%h/%b want=0000/0010", dig0, flg0);
        end
    endtask

    task automatic test_warning;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(109);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dig0 !== 16'h0011 || warn0 !== 1'b0) begin
            failures++; $display("FAIL warn_0011 got=%h warn=%b want=0011 warn=0", dig0, warn0);
        end
        ticks(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dig0 !== 16'h0010 || warn0 !== 1'b1) begin
            failures++; $display("FAIL warn_0010 got=%h warn=%b want=0010 warn=1", dig0, warn0);
        end
        for (int i = 1; i <= 10; i++) begin
            ticks(1);
            checks++;
            if (warn0 !== (i < 10)) begin
                failures++; $display("FAIL warn_hold_%0d got=%b want=%b", i, warn0, i < 10);
            end
        end
    endtask

    task automatic test_pause;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(30);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dig0 !== 16'h0130 || run0 !== 1'b0) begin
            failures++; $display("FAIL pause_tick got=%h run=%b want=0130 run=0", dig0, run0);
        end
        ticks(5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dig0 !== 16'h0130 || run0 !== 1'b1) begin
            failures++; $display("FAIL resume got=%h run=%b want=0130 run=1", dig0, run0);
        end
        ticks(1);
        checks++;
        if (dig0 !== 16'h0129) begin
            failures++; $display("FAIL resume_tick got=%h want=0129", dig0);
        end
    endtask

    task automatic test_up_mode;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (dig1 !== 16'(i) || tu1 !== (i == 5) || tup1 !== (i == 5)) begin
                failures++; $display("FAIL up_t%0d got=%h/%b want=%h", i, dig1, flg1, 16'(i));
            end
        end
        ticks(3);
        checks++;
        if (dig1 !== 16'h0005 || flg1 !== 4'b0010) begin
            failures++; $display("FAIL up_done_hold got=%h/%b want=0005/0010", dig1, flg1);
        end
        checks++;
        if (dig0 !== 16'h0008 || run0 !== 1'b1) begin
            failures++; $display("FAIL up_long got=%h run=%b want=0008 run=1", dig0, run0);
        end
    endtask

    task automatic test_done_reload;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(125);
        checks++;
        if (tu0 !== 1'b1 || dig0 !== 16'h0000) begin
            failures++; $display("FAIL done_reach got=%h/%b want=0000 time_up=1", dig0, flg0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dig0 !== 16'h0200 || flg0 !== 4'b0000) begin
            failures++; $display("FAIL load_start got=%h/%b want=0200/0000", dig0, flg0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flg0 !== 4'b1000 || dig0 !== 16'h0200) begin
            failures++; $display("FAIL reload_run got=%h/%b want=0200/1000", dig0, flg0);
        end
    endtask

    task automatic test_reset_midrun;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(83);
        checks++;
        if (dig0 !== 16'h0037) begin
            failures++; $display("FAIL pre_reset got=%h want=0037", dig0);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (dig0 !== 16'h0200 || flg0 !== 4'b0000 || flg1 !== 4'b0000) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b want=0200/0000/0000", dig0, flg0, flg1);
        end
        @(negedge clk);
        resetN = 1'b1;
        ticks(3);
        checks++;
        if (dig0 !== 16'h0200 || flg0 !== 4'b0000) begin
            failures++; $display("FAIL post_reset got=%h/%b want=0200/0000", dig0, flg0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (run0 !== 1'b1) begin
            failures++; $display("FAIL post_reset_start run=%b want=1", run0);
        end
    endtask

    task automatic test_random;
        logic [19:0] e0, e1;
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)));
            e0 = exp_vec(mdl[0]);
            e1 = exp_vec(mdl[1]);
            checks++;
            if ({dig0, flg0} !== e0) begin
                failures++; $display("FAIL rand_a cyc=%0d got=%h want=%h", i, {dig0, flg0}, e0);
            end
            checks++;
            if ({dig1, flg1} !== e1) begin
                failures++; $display("FAIL rand_b cyc=%0d got=%h want=%h", i, {dig1, flg1}, e1);
            end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_countdown;
        test_warning;
        test_pause;
        test_up_mode;
        test_done_reload;
        test_reset_midrun;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
